// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package cache_pkg;

  localparam int TAG_W      = 19;
  localparam int INDEX_W    = 11;
  localparam int LINE_BYTES = 4;

  typedef enum logic [1:0] {IDLE, WB, FILL, REFILL} cache_ctrl_state_t;

  // Saturating 32-bit increment used by the event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Hit / miss / write-back event counters for the cache controller.
// Only instantiated when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_stats
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        stat_clr,
  input  logic        hit,
  input  logic        miss,
  input  logic        wb_done,
  input  logic        refill,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_wbs
);

  // The IDLE cycle right after REFILL is the replay of the missed access;
  // it is not counted as a hit.
  logic retry_q;

  // Retry marker plus saturating counters; clear wins over any increment.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      retry_q     <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      retry_q <= refill;
      if (stat_clr) begin
        stat_hits   <= '0;
        stat_misses <= '0;
        stat_wbs    <= '0;
      end else begin
        if (hit && !retry_q) stat_hits <= sat_inc(stat_hits);
        if (miss)            stat_misses <= sat_inc(stat_misses);
        if (wb_done)         stat_wbs <= sat_inc(stat_wbs);
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped write-back data cache.
// Hits complete in the request cycle; misses write back a dirty victim,
// fetch the word, refill the line and replay the access.
// Optional: define CACHE_CTRL_STATS_EN to add hit/miss/write-back counters.
module cache_controller
  #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int INDEX_W = cache_pkg::INDEX_W
)(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic            cpu_is_byte,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            cpu_ready,
  input  logic            cache_hit,
  input  logic            cache_dirty,
  input  logic [XLEN-1:0] cache_miss_addr,
  input  logic [XLEN-1:0] cache_rdata,
  output logic            cache_we,
  output logic            cache_is_byte,
  output logic [XLEN-1:0] cache_addr,
  output logic [XLEN-1:0] cache_wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses,
  output logic [31:0]     stat_wbs
`endif
);

  import cache_pkg::*;

  // Byte-offset bits below the index; memory addresses are word aligned.
  localparam int OFF_W = XLEN - TAG_W - INDEX_W;

  cache_ctrl_state_t state;
  logic [XLEN-1:0]   fill_q;
  logic              hit_now;
  logic              miss_now;

  assign hit_now  = (state == IDLE) && cpu_req && cache_hit;
  assign miss_now = (state == IDLE) && cpu_req && !cache_hit;

  // Controller FSM; mem_req/mem_we are registered and stay up until mem_ack.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      fill_q  <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_now) begin
            state   <= cache_dirty ? WB : FILL;
            mem_req <= 1'b1;
            mem_we  <= cache_dirty;
          end
        end
        WB: begin
          if (mem_ack) begin
            state  <= FILL;
            mem_we <= 1'b0;
          end
        end
        FILL: begin
          if (mem_ack) begin
            fill_q  <= mem_rdata;
            state   <= REFILL;
            mem_req <= 1'b0;
          end
        end
        REFILL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request-cycle responses; gated by rst_b so they drop as soon as reset asserts.
  always_comb begin
    cpu_ready     = rst_b && hit_now;
    cache_we      = rst_b && ((hit_now && cpu_we) || (state == REFILL));
    cache_is_byte = rst_b && (state == IDLE) && cpu_is_byte;
    cache_addr    = cpu_addr;
    cache_wdata   = (state == REFILL) ? fill_q : cpu_wdata;
    mem_addr      = (state == WB) ? cache_miss_addr
                                  : {cpu_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    mem_wdata     = cache_rdata;
  end

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl_stats u_stats (
    .clk         (clk),
    .rst_b       (rst_b),
    .stat_clr    (stat_clr),
    .hit         (hit_now),
    .miss        (miss_now),
    .wb_done     ((state == WB) && mem_ack),
    .refill      (state == REFILL),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbs    (stat_wbs)
  );
`endif

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for the direct-mapped write-back data cache (2048 one-word lines, 19-bit tag, index `addr[12:2]`). It sits between the CPU load/store stage and the cache and main-memory ports. Hits are served in the request cycle. Misses stall the CPU while a dirty victim is written back, the line is fetched and the cache is refilled. It is the only master of the cache `we` strobe.

## Interface
Parameters:
- `XLEN`, 32: address and data width.
- `TAG_W`, 19: tag width, `addr[31:13]`.
- `INDEX_W`, 11: index width, `addr[12:2]`.

Ports:
- `clk`  in  1  clock
- `rst_b`  in  1  reset; asynchronous, active-low
- `cpu_req`  in  1  CPU access valid; held with all cpu_* stable until `cpu_ready`
- `cpu_we`  in  1  store (1) / load (0)
- `cpu_is_byte`  in  1  byte access (else word)
- `cpu_addr`  in  XLEN  byte address
- `cpu_wdata`  in  XLEN  store data; byte stores use bits [7:0]
- `cpu_ready`  out  1  access completes this cycle (combinational)
- `cache_hit`, `cache_dirty`  in  1 each  cache lookup results for `cache_addr`
- `cache_miss_addr`  in  XLEN  victim line address from the cache
- `cache_rdata`  in  XLEN  cache read word, packed {d[3],d[2],d[1],d[0]}
- `cache_we`  out  1  cache write strobe
- `cache_is_byte`  out  1  byte write/read select to cache
- `cache_addr`  out  XLEN  cache address: `cpu_addr` in all states
- `cache_wdata`  out  XLEN  `cpu_wdata` on hit stores, fill register in REFILL
- `mem_req`  out  1  memory request; held until `mem_ack`
- `mem_we`  out  1  write-back (1) / fetch (0)
- `mem_addr`  out  XLEN  word-aligned memory address
- `mem_wdata`  out  XLEN  victim word (`cache_rdata`)
- `mem_ack`  in  1  one-cycle completion pulse; fetch data valid with it
- `mem_rdata`  in  XLEN  fetched word

## Operation
States: IDLE, WB, FILL, REFILL.
- IDLE, `cpu_req & cache_hit`:
  - load: `cpu_ready`=1.
  - store: `cache_we`=1, `cache_is_byte`=`cpu_is_byte`, `cpu_ready`=1.
  - Stay in IDLE.
- IDLE, `cpu_req & !cache_hit`: go to WB if `cache_dirty`, else to FILL. `cpu_ready`=0 and `cache_we`=0 (the cache is never written on a miss).
- WB:
  - Drives `mem_req`=1, `mem_we`=1, `mem_addr`=`cache_miss_addr`, `mem_wdata`=`cache_rdata` with `cache_is_byte`=0.
  - On `mem_ack`, go to FILL.
- FILL:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`={`cpu_addr[31:2]`,2'b00}.
  - On `mem_ack`, latch `mem_rdata` into `fill_q` and go to REFILL.
- REFILL:
  - `cache_we`=1, `cache_is_byte`=0, `cache_wdata`=`fill_q`.
  - Next state IDLE. The cache installs the new tag with valid=1 and dirty=0.
  - The original access is then retried in IDLE and hits.
- `mem_req` is never withdrawn before `mem_ack`. `mem_ack` outside WB/FILL is ignored.
- Reset (any state, including mid-transfer): state=IDLE, `fill_q`=0. All outputs drop to 0 asynchronously (`cpu_ready`, `cache_we`, `mem_req`, `mem_we`). The memory side must abandon any in-flight transfer on reset.

## Timing
- Hit: 0 wait cycles. `cpu_ready` rises in the request cycle, and the store write takes effect at that clock edge.
- Clean miss: 1 (IDLE) + F (FILL, F = cycles up to and including ack, F≥1) + 1 (REFILL) + 1 (hit in IDLE) = F+3 cycles.
- Dirty miss: W+F+3 cycles, where W is the write-back cycle count.
- `mem_ack` may arrive in the first cycle of `mem_req`. No idle cycle is inserted between WB and FILL.
- `cpu_req` dropping while in WB/FILL/REFILL is a protocol violation; the sequence completes regardless.

## Configuration
- `CACHE_CTRL_STATS_EN` defined:
  - Adds 32-bit saturating counters `stat_hits`, `stat_misses`, `stat_wbs` as outputs.
  - `stat_hits` increments on IDLE hit completions, excluding the post-refill retry.
  - `stat_misses` increments on each IDLE→WB/FILL transition; `stat_wbs` on each WB ack.
  - Input `stat_clr` zeroes all three synchronously. Reset value is 0.
- Undefined: these ports and counters do not exist, and controller behaviour is otherwise identical.

## Structure
- Shared package `cache_pkg`:
  - `cache_ctrl_state_t` enum {IDLE, WB, FILL, REFILL}.
  - Constants `TAG_W`, `INDEX_W`, `LINE_BYTES`=4.
- The counters live in sub-module `cache_ctrl_stats`, instantiated only under the macro.

## Test plan
- Reset, then load 0x0000_1004 (cold miss) with ack after 3 cycles returning 0xDEADBEEF:
  - FILL `mem_addr`=0x0000_1004.
  - REFILL writes 0xDEADBEEF.
  - `cpu_ready` arrives 6 cycles after the request.
- Word store 0x12345678 to 0x0000_1004 (hit): `cpu_ready` in the same cycle, one `cache_we` pulse, no `mem_req`.
- Then load 0x0000_3004 (same index, dirty victim). Required sequence:
  - WB `mem_addr`=0x0000_1004 with `mem_wdata`=0x12345678.
  - Then FILL at 0x0000_3004, then hit.
- Byte store 0xAB to 0x0000_3006 (hit): `cache_is_byte`=1 and `cache_wdata[7:0]`=0xAB.
- Assert `rst_b` low during FILL before ack: outputs go to 0 immediately. After release the state is IDLE, and a repeated request re-misses with clean FILL.
- With `CACHE_CTRL_STATS_EN`, run the above sequence: hits=2, misses=2, wbs=1. After `stat_clr`, all counters are 0.
